// File: rtl/lsu_mem_responder_if.sv
// Load/store request and response bundle between the LSU and the memory responder.
interface lsu_mem_responder_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_complete;
  logic              store_req;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;
  logic              store_complete;

  modport master (
    output load_req, load_addr, store_req, store_addr, store_data,
    input  load_data, load_complete, store_complete
  );

  modport slave (
    input  load_req, load_addr, store_req, store_addr, store_data,
    output load_data, load_complete, store_complete
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU: single-port RAM with programmable latency,
// load/store arbitration and a backdoor init write port.
//   state  | meaning
//   IDLE   | no access in flight; grant a pending request if any
//   ACCESS | latency countdown for the granted request; commit at cnt==0
//   RESP   | complete pulse is high for this single cycle
module lsu_mem_responder #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  lsu_mem_responder_if.slave bus,
  input  logic              init_we,
  input  logic [MEM_AW-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              busy,
  output logic              proto_err,
  output logic              range_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                gnt_store, gnt_store_n;
  logic                last_store, last_store_n;
  logic                fin;
  logic                load_pend, load_pend_n;
  logic                store_pend, store_pend_n;
  logic                store_blk;
  logic [MEM_AW-1:0]   load_idx, store_idx;
  logic [DATA_W-1:0]   store_wdata;
  logic [DATA_W-1:0]   load_data_q;
  logic                load_cmp_q, store_cmp_q;
  logic                load_acc, store_acc, init_ok;
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [2**MEM_AW];

  assign bus.load_data      = load_data_q;
  assign bus.load_complete  = load_cmp_q;
  assign bus.store_complete = store_cmp_q;

  assign load_acc  = bus.load_req && !load_pend;
  assign store_acc = bus.store_req && !store_pend && !store_blk;
  assign init_ok   = init_we && !busy;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    gnt_store_n  = gnt_store;
    last_store_n = last_store;
    fin          = 1'b0;
    case (state)
      IDLE: begin
        if (load_pend && store_pend) begin
          // Ties alternate; only tied grants move the fairness pointer.
          gnt_store_n  = !last_store;
          last_store_n = !last_store;
          state_n      = ACCESS;
          cnt_n        = 4'(LAT - 1);
        end else if (load_pend || store_pend) begin
          gnt_store_n = store_pend;
          state_n     = ACCESS;
          cnt_n       = 4'(LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          fin     = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    load_pend_n  = load_pend;
    store_pend_n = store_pend;
    if (load_acc) load_pend_n = 1'b1;
    else if (fin && !gnt_store) load_pend_n = 1'b0;
    if (store_acc) store_pend_n = 1'b1;
    else if (fin && gnt_store) store_pend_n = 1'b0;
  end

  // A commit only happens while busy, so it never collides with an init write.
  assign mem_we    = init_ok || (fin && gnt_store);
  assign mem_waddr = (fin && gnt_store) ? store_idx : init_addr;
  assign mem_wdata = (fin && gnt_store) ? store_wdata : init_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_store   <= 1'b0;
      last_store  <= 1'b1;
      load_pend   <= 1'b0;
      store_pend  <= 1'b0;
      store_blk   <= 1'b0;
      load_idx    <= '0;
      store_idx   <= '0;
      store_wdata <= '0;
      load_data_q <= '0;
      load_cmp_q  <= 1'b0;
      store_cmp_q <= 1'b0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      gnt_store  <= gnt_store_n;
      last_store <= last_store_n;
      load_pend  <= load_pend_n;
      store_pend <= store_pend_n;
      busy       <= load_pend_n | store_pend_n | (state_n != IDLE);
      load_cmp_q  <= fin && !gnt_store;
      store_cmp_q <= fin && gnt_store;
      if (fin && !gnt_store) load_data_q <= mem[load_idx];
      if (load_acc) begin
        load_idx <= bus.load_addr[MEM_AW-1:0];
        if (|bus.load_addr[ADDR_W-1:MEM_AW]) range_err <= 1'b1;
      end
      if (store_acc) begin
        store_idx   <= bus.store_addr[MEM_AW-1:0];
        store_wdata <= bus.store_data;
        if (|bus.store_addr[ADDR_W-1:MEM_AW]) range_err <= 1'b1;
      end
      if ((bus.load_req && load_pend) || (init_we && busy)) proto_err <= 1'b1;
      // Blocks re-acceptance of a store request still held after its completion.
      if (fin && gnt_store) store_blk <= 1'b1;
      else if (!bus.store_req) store_blk <= 1'b0;
    end
  end

endmodule
